// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle control FSM for the 16-bit datapath
module mc_control_fsm #(
   parameter int STATE_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         opcode,
   input  logic [3:0]         ext_op,
   input  logic               cond_true,
   input  logic               mem_ready,
   output logic               mem_read,
   output logic               mem_write,
   output logic               addr_sel,
   output logic               ir_en,
   output logic               mdr_en,
   output logic               pc_en,
   output logic [1:0]         pc_sel,
   output logic [1:0]         alu_src_b,
   output logic               flags_en,
   output logic               reg_write,
   output logic [1:0]         wb_sel,
   output logic               illegal,
   output logic [STATE_W-1:0] state_dbg
);

   localparam logic [STATE_W-1:0] S_FETCH  = 3'd0;
   localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
   localparam logic [STATE_W-1:0] S_EXEC   = 3'd2;
   localparam logic [STATE_W-1:0] S_MEMRD  = 3'd3;
   localparam logic [STATE_W-1:0] S_MEMWR  = 3'd4;
   localparam logic [STATE_W-1:0] S_WB     = 3'd5;
   localparam logic [STATE_W-1:0] S_BRANCH = 3'd6;
   localparam logic [STATE_W-1:0] S_JUMP   = 3'd7;

   localparam logic [2:0] C_R     = 3'd0;
   localparam logic [2:0] C_IMM   = 3'd1;
   localparam logic [2:0] C_LUI   = 3'd2;
   localparam logic [2:0] C_LOAD  = 3'd3;
   localparam logic [2:0] C_STOR  = 3'd4;
   localparam logic [2:0] C_BCOND = 3'd5;
   localparam logic [2:0] C_JCOND = 3'd6;
   localparam logic [2:0] C_ILL   = 3'd7;

   logic [STATE_W-1:0] state_q, state_d;
   logic [STATE_W-1:0] cur_state;
   logic [2:0]         cls;

   // While reset is held low the outputs decode as FETCH with all enables suppressed.
   assign cur_state = reset ? state_q : S_FETCH;
   assign state_dbg = state_q;

   // Instruction class decode from the IR opcode fields.
   always_comb begin
      cls = C_IMM;
      case (opcode)
         4'b0000: cls = C_R;
         4'b1111: cls = C_LUI;
         4'b1100: cls = C_BCOND;
         4'b0100: begin
            case (ext_op)
               4'b0000: cls = C_LOAD;
               4'b0100: cls = C_STOR;
               4'b1100: cls = C_JCOND;
               default: cls = C_ILL;
            endcase
         end
         default: cls = C_IMM;
      endcase
   end

   // State register; active-low reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (cls)
               C_R, C_IMM, C_LUI: state_d = S_EXEC;
               C_LOAD:            state_d = S_MEMRD;
               C_STOR:            state_d = S_MEMWR;
               C_BCOND:           state_d = S_BRANCH;
               C_JCOND:           state_d = S_JUMP;
               default:           state_d = S_FETCH;
            endcase
         end
         S_EXEC:   state_d = S_WB;
         S_MEMRD:  if (mem_ready) state_d = S_WB;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_WB:     state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // Datapath control outputs decoded from the current state and class.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr_sel  = 1'b0;
      ir_en     = 1'b0;
      mdr_en    = 1'b0;
      pc_en     = 1'b0;
      pc_sel    = 2'b00;
      alu_src_b = 2'b00;
      flags_en  = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'b00;
      illegal   = 1'b0;
      case (cur_state)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready && reset) begin
               ir_en = 1'b1;
               pc_en = 1'b1;
            end
         end
         S_DECODE: illegal = (cls == C_ILL);
         S_EXEC: begin
            alu_src_b = (cls == C_R) ? 2'b00 : 2'b01;
            flags_en  = (cls == C_R) || (cls == C_IMM);
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            addr_sel = 1'b1;
            mdr_en   = mem_ready;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            addr_sel  = 1'b1;
         end
         S_WB: begin
            reg_write = 1'b1;
            if (cls == C_LOAD)     wb_sel = 2'b01;
            else if (cls == C_LUI) wb_sel = 2'b10;
            else                   wb_sel = 2'b00;
         end
         S_BRANCH: if (cond_true) begin
            pc_en  = 1'b1;
            pc_sel = 2'b01;
         end
         S_JUMP: if (cond_true) begin
            pc_en  = 1'b1;
            pc_sel = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed self-checking bench for mc_control_fsm
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] opcode, ext_op;
   logic       cond_true, mem_ready;
   logic       mem_read, mem_write, addr_sel, ir_en, mdr_en, pc_en;
   logic [1:0] pc_sel, alu_src_b, wb_sel;
   logic       flags_en, reg_write, illegal;
   logic [2:0] state_dbg;

   int errors = 0;
   int checks = 0;

   mc_control_fsm #(.STATE_W(3)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .ext_op(ext_op),
      .cond_true(cond_true), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
      .ir_en(ir_en), .mdr_en(mdr_en), .pc_en(pc_en), .pc_sel(pc_sel),
      .alu_src_b(alu_src_b), .flags_en(flags_en), .reg_write(reg_write),
      .wb_sel(wb_sel), .illegal(illegal), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; opcode = 4'h0; ext_op = 4'h0; cond_true = 1'b0; mem_ready = 1'b0;
      tick();
      mem_ready = 1'b1; #1;
      chk("rst_ir_en", {7'd0, ir_en}, 8'd0);
      chk("rst_pc_en", {7'd0, pc_en}, 8'd0);
      tick();
      chk("rst_state", {5'd0, state_dbg}, 8'd0);

      // R-type with no waits: 0,1,2,5,0
      reset = 1'b1; opcode = 4'b0000; #1;
      chk("r_fetch_state", {5'd0, state_dbg}, 8'd0);
      chk("r_fetch_ir_pc", {6'd0, ir_en, pc_en}, 8'h03);
      chk("r_fetch_rd", {6'd0, mem_read, addr_sel}, 8'h02);
      tick();
      chk("r_dec_state", {5'd0, state_dbg}, 8'd1);
      chk("r_dec_en", {5'd0, ir_en, pc_en, reg_write}, 8'd0);
      tick();
      chk("r_exec_state", {5'd0, state_dbg}, 8'd2);
      chk("r_exec_flags", {5'd0, flags_en, alu_src_b}, 8'h04);
      tick();
      chk("r_wb_state", {5'd0, state_dbg}, 8'd5);
      chk("r_wb_ctl", {5'd0, reg_write, wb_sel}, 8'h04);
      chk("r_wb_ir_pc", {6'd0, ir_en, pc_en}, 8'h00);
      tick();
      chk("r_done_state", {5'd0, state_dbg}, 8'd0);

      // FETCH waits while memory not ready
      mem_ready = 1'b0; #1;
      chk("fetch_wait_en", {6'd0, ir_en, pc_en}, 8'h00);
      tick();
      chk("fetch_wait_state", {5'd0, state_dbg}, 8'd0);

      // LOAD with two wait states in MEMRD
      opcode = 4'b0100; ext_op = 4'b0000; mem_ready = 1'b1;
      tick();
      chk("ld_dec_state", {5'd0, state_dbg}, 8'd1);
      mem_ready = 1'b0;
      tick();
      chk("ld_rd_w1", {4'd0, state_dbg, mdr_en}, 8'h06);
      chk("ld_rd_w1_req", {6'd0, mem_read, addr_sel}, 8'h03);
      tick();
      chk("ld_rd_w2", {4'd0, state_dbg, mdr_en}, 8'h06);
      chk("ld_rd_w2_req", {6'd0, mem_read, addr_sel}, 8'h03);
      mem_ready = 1'b1; #1;
      chk("ld_rd_rdy", {4'd0, state_dbg, mdr_en}, 8'h07);
      chk("ld_rd_rdy_req", {5'd0, mem_read, addr_sel, ir_en}, 8'h06);
      tick();
      chk("ld_wb", {2'd0, state_dbg, reg_write, wb_sel}, 8'h2D);
      tick();
      chk("ld_done_state", {5'd0, state_dbg}, 8'd0);

      // STOR, no waits
      ext_op = 4'b0100;
      tick(); tick();
      chk("st_wr_state", {5'd0, state_dbg}, 8'd4);
      chk("st_wr_ctl", {5'd0, mem_write, mem_read, addr_sel}, 8'h05);
      chk("st_wr_regw", {7'd0, reg_write}, 8'd0);
      tick();
      chk("st_done_state", {5'd0, state_dbg}, 8'd0);

      // BCOND taken then not taken
      opcode = 4'b1100; cond_true = 1'b1;
      tick(); tick();
      chk("bc_t_state", {5'd0, state_dbg}, 8'd6);
      chk("bc_t_pc", {5'd0, pc_en, pc_sel}, 8'h05);
      tick();
      chk("bc_t_done", {5'd0, state_dbg}, 8'd0);
      cond_true = 1'b0;
      tick(); tick();
      chk("bc_nt_state", {5'd0, state_dbg}, 8'd6);
      chk("bc_nt_pc", {5'd0, pc_en, pc_sel}, 8'h00);
      tick();
      chk("bc_nt_done", {5'd0, state_dbg}, 8'd0);

      // JCOND taken
      opcode = 4'b0100; ext_op = 4'b1100; cond_true = 1'b1;
      tick(); tick();
      chk("jc_state", {5'd0, state_dbg}, 8'd7);
      chk("jc_pc", {5'd0, pc_en, pc_sel}, 8'h06);
      tick();
      chk("jc_done", {5'd0, state_dbg}, 8'd0);

      // Illegal encoding
      ext_op = 4'b0010; cond_true = 1'b0;
      tick();
      chk("ill_dec", {4'd0, state_dbg, illegal}, 8'h03);
      chk("ill_quiet", {5'd0, reg_write, pc_en, mem_write}, 8'h00);
      tick();
      chk("ill_next", {4'd0, state_dbg, illegal}, 8'h00);

      // IMM (opcode 0001)
      opcode = 4'b0001;
      tick(); tick();
      chk("imm_exec", {5'd0, flags_en, alu_src_b}, 8'h05);
      tick();
      chk("imm_wb", {5'd0, reg_write, wb_sel}, 8'h04);
      tick();

      // Reset mid-MEMWR while memory stalls
      opcode = 4'b0100; ext_op = 4'b0100;
      tick();
      mem_ready = 1'b0;
      tick();
      chk("rmw_state", {4'd0, state_dbg, mem_write}, 8'h09);
      tick();
      chk("rmw_hold", {4'd0, state_dbg, mem_write}, 8'h09);
      reset = 1'b0;
      tick();
      chk("rmw_reset", {4'd0, state_dbg, mem_write}, 8'h00);
      reset = 1'b1;

      // LUI afterwards
      opcode = 4'b1111; mem_ready = 1'b1;
      tick(); tick();
      chk("lui_exec", {2'd0, state_dbg, flags_en, alu_src_b}, 8'h11);
      tick();
      chk("lui_wb", {5'd0, reg_write, wb_sel}, 8'h06);
      tick();
      chk("lui_done", {5'd0, state_dbg}, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
